// File: rtl/bcd_score_counter_if.sv
// Player score bundle: point/penalty requests in, BCD score, segments and status out.
interface bcd_score_counter_if #(
  parameter int DIGITS = 3
);
  logic                  point;
  logic                  penalty;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [7*DIGITS-1:0]   hex;
  logic                  win;
  logic                  overflow;
  logic                  point_ack;

  modport master (
    output point, penalty,
    input  score_bcd, hex, win, overflow, point_ack
  );

  modport slave (
    input  point, penalty,
    output score_bcd, hex, win, overflow, point_ack
  );
endinterface

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with debounced point input, penalty decrement,
// win detection and per-digit active-low 7-segment outputs.
module bcd_score_counter #(
  parameter int DIGITS        = 3,
  parameter int COOLDOWN      = 1024,
  parameter bit SATURATE      = 1'b1,
  parameter int WIN_SCORE     = 21,
  parameter bit FREEZE_ON_WIN = 1'b1,
  parameter bit BLANK_LZ      = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  bcd_score_counter_if.slave  bus
);

  localparam int W         = 4 * DIGITS;
  localparam int CW        = $clog2(COOLDOWN + 1);
  localparam int MAX_SCORE = (10 ** DIGITS) - 1;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  // A threshold beyond the display range can never be reached.
  localparam logic         WIN_REACHABLE = (WIN_SCORE >= 0) && (WIN_SCORE <= MAX_SCORE);
  localparam logic [W-1:0] WIN_BCD       = to_bcd(WIN_REACHABLE ? WIN_SCORE : 0);

  logic [W-1:0]   score_q;
  logic [CW-1:0]  cd_q;
  logic           point_q;
  logic           overflow_q;
  logic           ack_q;

  logic           win_c;
  logic           frozen;
  logic           edge_c;
  logic           accepted;
  logic           dec_ok;
  logic [W-1:0]   inc_val;
  logic [W-1:0]   dec_val;
  logic           all_nines;
  logic           borrow;
  logic [7*DIGITS-1:0] hex_c;
  logic           leading;

  // Packed-BCD magnitude order matches decimal order, so a plain compare works.
  assign win_c    = WIN_REACHABLE && (score_q >= WIN_BCD);
  assign frozen   = FREEZE_ON_WIN && win_c;
  assign edge_c   = bus.point && !point_q;
  assign accepted = edge_c && (cd_q == CW'(COOLDOWN)) && !frozen;
  assign dec_ok   = bus.penalty && !frozen;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    inc_val   = score_q;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (all_nines) begin
        if (inc_val[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = inc_val[4*i +: 4] + 4'd1;
          all_nines         = 1'b0;
        end
      end
    end

    dec_val = score_q;
    borrow  = (score_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (dec_val[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = dec_val[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Scan from the most significant digit; blanking stops at the first nonzero digit.
  always_comb begin
    hex_c   = '1;
    leading = BLANK_LZ;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (leading && (i > 0) && (score_q[4*i +: 4] == 4'd0)) begin
        hex_c[7*i +: 7] = 7'h7F;
      end else begin
        hex_c[7*i +: 7] = seg(score_q[4*i +: 4]);
        leading         = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q    <= '0;
      cd_q       <= CW'(COOLDOWN);
      point_q    <= 1'b0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      point_q <= bus.point;
      ack_q   <= accepted;

      if (accepted) begin
        cd_q <= '0;
      end else if (cd_q != CW'(COOLDOWN)) begin
        cd_q <= cd_q + CW'(1);
      end

      // Simultaneous accept and penalty cancel out.
      if (accepted && !dec_ok) begin
        if (all_nines) begin
          overflow_q <= 1'b1;
          if (!SATURATE) begin
            score_q <= '0;
          end
        end else begin
          score_q <= inc_val;
        end
      end else if (dec_ok && !accepted) begin
        score_q <= dec_val;
      end
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.hex       = hex_c;
  assign bus.win       = win_c;
  assign bus.overflow  = overflow_q;
  assign bus.point_ack = ack_q;

endmodule
